// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded control, operands and status
// flags for the execute stage, with flush (bubble), freeze (hold), a valid
// tag and a saturating bubble counter for performance debug.
// Optional feature: define ID_EXE_FWD_EN to register the source register
// numbers for the forwarding unit; otherwise exe_src1/exe_src2 are tied to 0.
module id_exe_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [3:0]       id_exec_cmd,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_wb_en,
    input  logic             id_s,
    input  logic             id_b,
    input  logic [31:0]      id_val_rn,
    input  logic [31:0]      id_val_rm,
    input  logic             id_imm,
    input  logic [11:0]      id_shift_operand,
    input  logic [23:0]      id_signed_imm_24,
    input  logic [3:0]       id_dest,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic [3:0]       id_status,
    output logic             exe_valid,
    output logic [31:0]      exe_pc,
    output logic [3:0]       exe_exec_cmd,
    output logic             exe_mem_r_en,
    output logic             exe_mem_w_en,
    output logic             exe_wb_en,
    output logic             exe_s,
    output logic             exe_b,
    output logic [31:0]      exe_val_rn,
    output logic [31:0]      exe_val_rm,
    output logic             exe_imm,
    output logic [11:0]      exe_shift_operand,
    output logic [23:0]      exe_signed_imm_24,
    output logic [3:0]       exe_dest,
    output logic [3:0]       exe_src1,
    output logic [3:0]       exe_src2,
    output logic [3:0]       exe_status,
    output logic             exe_cin,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage register: flush beats freeze beats load; invalid loads clear control
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            exe_valid         <= 1'b0;
            exe_pc            <= 32'd0;
            exe_exec_cmd      <= 4'd0;
            exe_mem_r_en      <= 1'b0;
            exe_mem_w_en      <= 1'b0;
            exe_wb_en         <= 1'b0;
            exe_s             <= 1'b0;
            exe_b             <= 1'b0;
            exe_val_rn        <= 32'd0;
            exe_val_rm        <= 32'd0;
            exe_imm           <= 1'b0;
            exe_shift_operand <= 12'd0;
            exe_signed_imm_24 <= 24'd0;
            exe_dest          <= 4'd0;
            exe_status        <= 4'd0;
        end else if (!freeze) begin
            exe_valid         <= id_valid;
            exe_pc            <= id_pc;
            exe_exec_cmd      <= id_exec_cmd;
            exe_mem_r_en      <= id_mem_r_en & id_valid;
            exe_mem_w_en      <= id_mem_w_en & id_valid;
            exe_wb_en         <= id_wb_en & id_valid;
            exe_s             <= id_s & id_valid;
            exe_b             <= id_b & id_valid;
            exe_val_rn        <= id_val_rn;
            exe_val_rm        <= id_val_rm;
            exe_imm           <= id_imm;
            exe_shift_operand <= id_shift_operand;
            exe_signed_imm_24 <= id_signed_imm_24;
            exe_dest          <= id_dest;
            exe_status        <= id_status;
        end
    end

`ifdef ID_EXE_FWD_EN
    // Source register numbers for forwarding follow the same hold/bubble rules
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            exe_src1 <= 4'd0;
            exe_src2 <= 4'd0;
        end else if (!freeze) begin
            exe_src1 <= id_src1;
            exe_src2 <= id_src2;
        end
    end
`else
    // No forwarding unit: sources are not needed downstream
    logic unused_src;
    assign unused_src = ^{id_src1, id_src2};
    assign exe_src1   = 4'd0;
    assign exe_src2   = 4'd0;
`endif

    // Saturating bubble counter, counts flush cycles only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (flush && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // ALU carry-in is the C flag captured with this instruction
    assign exe_cin = exe_status[2];

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed, table-driven bench for id_exe_reg (instantiated with CNT_W=2).
module tb_id_exe_reg;

    localparam int unsigned CNT_W = 2;
`ifdef ID_EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             freeze, flush, id_valid;
    logic [31:0]      id_pc;
    logic [3:0]       id_exec_cmd;
    logic             id_mem_r_en, id_mem_w_en, id_wb_en, id_s, id_b;
    logic [31:0]      id_val_rn, id_val_rm;
    logic             id_imm;
    logic [11:0]      id_shift_operand;
    logic [23:0]      id_signed_imm_24;
    logic [3:0]       id_dest, id_src1, id_src2, id_status;
    logic             exe_valid;
    logic [31:0]      exe_pc;
    logic [3:0]       exe_exec_cmd;
    logic             exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_s, exe_b;
    logic [31:0]      exe_val_rn, exe_val_rm;
    logic             exe_imm;
    logic [11:0]      exe_shift_operand;
    logic [23:0]      exe_signed_imm_24;
    logic [3:0]       exe_dest, exe_src1, exe_src2, exe_status;
    logic             exe_cin;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_exec_cmd(id_exec_cmd), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en), .id_s(id_s), .id_b(id_b),
        .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_status(id_status),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_exec_cmd(exe_exec_cmd),
        .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
        .exe_s(exe_s), .exe_b(exe_b), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
        .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
        .exe_signed_imm_24(exe_signed_imm_24), .exe_dest(exe_dest), .exe_src1(exe_src1),
        .exe_src2(exe_src2), .exe_status(exe_status), .exe_cin(exe_cin),
        .bubble_cnt(bubble_cnt)
    );

    // ctrl / e_ctrl bit order: {wb_en, mem_r_en, mem_w_en, s, b}
    typedef struct {
        logic        flush, freeze, valid;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic [4:0]  ctrl;
        logic [31:0] rn, rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] off;
        logic [3:0]  dest, src1, src2, status;
        logic [31:0] e_pc;
        logic [3:0]  e_cmd;
        logic [4:0]  e_ctrl;
        logic        e_valid;
        logic [31:0] e_rn, e_rm;
        logic        e_imm;
        logic [11:0] e_shift;
        logic [23:0] e_off;
        logic [3:0]  e_dest, e_src1, e_src2, e_status;
        logic        e_cin;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush = v.flush; freeze = v.freeze; id_valid = v.valid;
        id_pc = v.pc; id_exec_cmd = v.cmd;
        {id_wb_en, id_mem_r_en, id_mem_w_en, id_s, id_b} = v.ctrl;
        id_val_rn = v.rn; id_val_rm = v.rm; id_imm = v.imm;
        id_shift_operand = v.shift; id_signed_imm_24 = v.off;
        id_dest = v.dest; id_src1 = v.src1; id_src2 = v.src2; id_status = v.status;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc"},     exe_pc, 32'd0);
        check({tag, ".cmd"},    32'(exe_exec_cmd), 32'd0);
        check({tag, ".ctrl"},   32'({exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_s, exe_b}), 32'd0);
        check({tag, ".valid"},  32'(exe_valid), 32'd0);
        check({tag, ".rn"},     exe_val_rn, 32'd0);
        check({tag, ".rm"},     exe_val_rm, 32'd0);
        check({tag, ".misc"},   32'({exe_imm, exe_shift_operand, exe_dest}), 32'd0);
        check({tag, ".off"},    32'(exe_signed_imm_24), 32'd0);
        check({tag, ".src"},    32'({exe_src1, exe_src2}), 32'd0);
        check({tag, ".status"}, 32'(exe_status), 32'd0);
        check({tag, ".cin"},    32'(exe_cin), 32'd0);
        check({tag, ".cnt"},    32'(bubble_cnt), 32'd0);
    endtask

    initial begin
        vec_t z;
        // row 0: plain valid load
        vecs[0] = '{1'b0,1'b0,1'b1, 32'h4, 4'b0010, 5'b10000, 32'h5, 32'h7, 1'b1, 12'h123, 24'h000010,
                    4'h3, 4'h1, 4'h2, 4'b0000,
                    32'h4, 4'b0010, 5'b10000, 1'b1, 32'h5, 32'h7, 1'b1, 12'h123, 24'h000010,
                    4'h3, FWD ? 4'h1 : 4'h0, FWD ? 4'h2 : 4'h0, 4'b0000, 1'b0, 2'd0};
        // row 1: invalid instruction, control gated, data kept, no bubble count
        vecs[1] = '{1'b0,1'b0,1'b0, 32'h8, 4'b0100, 5'b11111, 32'h11, 32'hDEAD_BEEF, 1'b0, 12'h0AB, 24'hFFFFFE,
                    4'h5, 4'h6, 4'h7, 4'b1111,
                    32'h8, 4'b0100, 5'b00000, 1'b0, 32'h11, 32'hDEAD_BEEF, 1'b0, 12'h0AB, 24'hFFFFFE,
                    4'h5, FWD ? 4'h6 : 4'h0, FWD ? 4'h7 : 4'h0, 4'b1111, 1'b1, 2'd0};
        // row 2: flush and freeze together -> bubble, count 1
        vecs[2] = '{1'b1,1'b1,1'b1, 32'hC, 4'b1001, 5'b10100, 32'h22, 32'h33, 1'b1, 12'hFFF, 24'h123456,
                    4'h9, 4'h8, 4'h9, 4'b1010,
                    32'h0, 4'h0, 5'b00000, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0, 24'h0,
                    4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1};
        // row 3: status with C set -> carry-in 1
        vecs[3] = '{1'b0,1'b0,1'b1, 32'h10, 4'b0001, 5'b00011, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 12'h801, 24'h000ABC,
                    4'hE, 4'h3, 4'h4, 4'b0100,
                    32'h10, 4'b0001, 5'b00011, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 12'h801, 24'h000ABC,
                    4'hE, FWD ? 4'h3 : 4'h0, FWD ? 4'h4 : 4'h0, 4'b0100, 1'b1, 2'd1};
        // row 4: freeze with different inputs -> hold row 3
        vecs[4] = '{1'b0,1'b1,1'b1, 32'h99, 4'b1111, 5'b11111, 32'h1, 32'h2, 1'b1, 12'h001, 24'h000001,
                    4'h1, 4'h5, 4'h5, 4'b0000,
                    32'h10, 4'b0001, 5'b00011, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 12'h801, 24'h000ABC,
                    4'hE, FWD ? 4'h3 : 4'h0, FWD ? 4'h4 : 4'h0, 4'b0100, 1'b1, 2'd1};
        // row 5: src1 = A
        vecs[5] = '{1'b0,1'b0,1'b1, 32'h14, 4'b0010, 5'b01000, 32'h0, 32'h0, 1'b0, 12'h0, 24'h0,
                    4'h0, 4'hA, 4'hB, 4'b0000,
                    32'h14, 4'b0010, 5'b01000, 1'b1, 32'h0, 32'h0, 1'b0, 12'h0, 24'h0,
                    4'h0, FWD ? 4'hA : 4'h0, FWD ? 4'hB : 4'h0, 4'b0000, 1'b0, 2'd1};
        // rows 6-9: flush only; counter 2, 3, 3, 3 (saturated)
        for (int i = 6; i < NV; i++) begin
            vecs[i] = '{1'b1,1'b0,1'b1, 32'hFF, 4'hF, 5'b11111, 32'h1, 32'h1, 1'b1, 12'h001, 24'h000001,
                        4'h1, 4'h1, 4'h1, 4'hF,
                        32'h0, 4'h0, 5'b00000, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0, 24'h0,
                        4'h0, 4'h0, 4'h0, 4'h0, 1'b0, (i == 6) ? 2'd2 : 2'd3};
        end

        // reset
        z = vecs[2];
        z.flush = 1'b0; z.freeze = 1'b0; z.valid = 1'b0;
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.pc", i),     exe_pc, vecs[i].e_pc);
            check($sformatf("v%0d.cmd", i),    32'(exe_exec_cmd), 32'(vecs[i].e_cmd));
            check($sformatf("v%0d.ctrl", i),
                  32'({exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_s, exe_b}), 32'(vecs[i].e_ctrl));
            check($sformatf("v%0d.valid", i),  32'(exe_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d.rn", i),     exe_val_rn, vecs[i].e_rn);
            check($sformatf("v%0d.rm", i),     exe_val_rm, vecs[i].e_rm);
            check($sformatf("v%0d.imm", i),    32'(exe_imm), 32'(vecs[i].e_imm));
            check($sformatf("v%0d.shift", i),  32'(exe_shift_operand), 32'(vecs[i].e_shift));
            check($sformatf("v%0d.off", i),    32'(exe_signed_imm_24), 32'(vecs[i].e_off));
            check($sformatf("v%0d.dest", i),   32'(exe_dest), 32'(vecs[i].e_dest));
            check($sformatf("v%0d.src1", i),   32'(exe_src1), 32'(vecs[i].e_src1));
            check($sformatf("v%0d.src2", i),   32'(exe_src2), 32'(vecs[i].e_src2));
            check($sformatf("v%0d.status", i), 32'(exe_status), 32'(vecs[i].e_status));
            check($sformatf("v%0d.cin", i),    32'(exe_cin), 32'(vecs[i].e_cin));
            check($sformatf("v%0d.cnt", i),    32'(bubble_cnt), 32'(vecs[i].e_cnt));
        end

        // multi-cycle freeze: pc 0x10 held for 3 edges while inputs show 0x14
        z = vecs[5];
        z.pc = 32'h10; z.ctrl = 5'b10000; z.status = 4'b0100;
        drive(z);
        @(posedge clk);
        #1;
        check("frz.load", exe_pc, 32'h10);
        freeze = 1'b1;
        id_pc  = 32'h14;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("frz.hold%0d", k), exe_pc, 32'h10);
        end
        check("frz.cnt", 32'(bubble_cnt), 32'd3);
        freeze = 1'b0;
        @(posedge clk);
        #1;
        check("frz.release", exe_pc, 32'h14);
        check("frz.wb", 32'(exe_wb_en), 32'd1);

        // asynchronous reset mid-cycle with non-zero contents
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("areset");
        @(negedge clk);
        rst = 1'b0;

        // first edge after release loads normally
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check("post.pc", exe_pc, 32'h4);
        check("post.valid", 32'(exe_valid), 32'd1);
        check("post.cnt", 32'(bubble_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
